pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 5, width of the control bundle (e.g. Branch, MemRead, MemtoReg, MemWrite, RegWrite).
REQ-002 Parameter DATA_W, default 102, width of the payload bundle (e.g. ALU result, zero flag, branch address, store data, rd).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous kill of all held beats.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  stage can accept a beat this cycle.
REQ-008 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  downstream beat present.
REQ-011 out_ready  input  1  downstream accepts this cycle.
REQ-012 out_ctrl  output  CTRL_W  registered control; all-zero whenever out_valid=0.
REQ-013 out_data  output  DATA_W  registered payload; holds its last value when out_valid=0.

Function
REQ-014 Input transfer occurs when in_valid=1 and in_ready=1; output transfer occurs when out_valid=1 and out_ready=1.
REQ-015 Latency: an accepted beat appears on out_* exactly one cycle after acceptance if the output slot is free.
REQ-016 Without skid: in_ready = out_ready OR NOT out_valid (combinational pass-through of backpressure).
REQ-017 Output slot loads in_ctrl/in_data on input transfer; if output transfer occurs with no input transfer, out_valid clears and out_ctrl becomes 0 next cycle.
REQ-018 Stall (out_valid=1, out_ready=0) holds out_valid, out_ctrl and out_data unchanged.
REQ-019 Simultaneous input and output transfer: output slot replaced by the new beat; out_valid stays 1.
REQ-020 flush has priority over every transfer: next cycle out_valid=0, out_ctrl=0, skid slot empty; any beat accepted in the flush cycle is discarded.
REQ-021 Beats are never duplicated, dropped (except by flush) or reordered.
REQ-022 A bubble (out_valid=0) never presents a nonzero control bit, so no write-enable fires from it.

Reset
REQ-023 On rst: out_valid=0, out_ctrl=0, out_data=0, skid slot empty and zeroed, immediately and independent of clk.
REQ-024 rst asserted mid-stall discards all held beats; first cycle after release in_ready=1.

Configuration
REQ-025 Macro PIPE_STAGE_SKID_EN compiled in: one skid slot added, capacity 2 beats; in_ready is registered and equals NOT skid_valid (no combinational path from out_ready).
REQ-026 With PIPE_STAGE_SKID_EN: beat accepted while output stalled goes to skid slot; on next output transfer skid moves to output slot; skid beat always leaves before any newer beat.
REQ-027 Without PIPE_STAGE_SKID_EN: single slot, behaviour per REQ-016; no skid storage synthesised.

Structure
REQ-028 Shared package pipe_pkg holds default CTRL_W/DATA_W constants and control-bit index constants (BRANCH, MEMREAD, MEMTOREG, MEMWRITE, REGWRITE).
REQ-029 Skid storage is sub-module pipe_skid_slot (valid + ctrl + data register with load/clear), instantiated only under PIPE_STAGE_SKID_EN.

Verification
REQ-030 Reset: assert rst with in_valid=1, in_ctrl=5'b11111 -> out_valid=0, out_ctrl=0, out_data=0 during and one cycle after release.
REQ-031 Streaming: out_ready=1, beats data 1..8 on consecutive cycles -> out_data 1..8 one cycle later each, out_valid continuously 1.
REQ-032 Stall: load data 0xA5, ctrl 5'b00001, hold out_ready=0 for 4 cycles -> outputs unchanged, in_ready=0 (no skid) or accepts exactly one extra beat then in_ready=0 (skid).
REQ-033 Flush: with out_valid=1 ctrl 5'b01001 and skid full, pulse flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, no beat emitted.
REQ-034 Skid order: beats 0x10, 0x11 accepted during stall, then out_ready=1 -> out_data 0x10 then 0x11, no gap, no duplicate.
REQ-035 Bubble control: in_valid=0 with in_ctrl=5'b11111 for 3 cycles -> out_ctrl=0 throughout.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for pipeline stage registers: default bundle widths and
// control-bit positions within the control bundle.
package pipe_pkg;

  localparam int CTRL_W_DEF = 5;
  localparam int DATA_W_DEF = 102;

  localparam int BRANCH   = 0;
  localparam int MEMREAD  = 1;
  localparam int MEMTOREG = 2;
  localparam int MEMWRITE = 3;
  localparam int REGWRITE = 4;

endpackage

// File: rtl/pipe_skid_slot.sv
// One-beat holding register (valid + ctrl + data) with load and clear.
// Clear wins over load and zeroes the whole slot.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register for a control + payload bundle.
// Define PIPE_STAGE_SKID_EN to add a skid slot and register in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  logic              out_free;
  logic              in_xfer;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // Output slot can take a new beat this cycle: empty or being drained.
  assign out_free = ~out_valid | out_ready;
  assign in_xfer  = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic skid_load;
  logic skid_clear;

  // skid_valid is a flop, so in_ready has no path from out_ready.
  assign in_ready   = ~skid_valid;
  assign skid_load  = in_xfer & ~out_free & ~flush;
  assign skid_clear = flush | (out_free & skid_valid);

  pipe_skid_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clear   (skid_clear),
    .load    (skid_load),
    .in_ctrl (in_ctrl),
    .in_data (in_data),
    .valid   (skid_valid),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );
`else
  assign in_ready   = out_free;
  assign skid_valid = 1'b0;
  assign skid_ctrl  = '0;
  assign skid_data  = '0;
`endif

  // The skid beat is always older than anything on the input, so it goes first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid <= 1'b1;
        out_ctrl  <= skid_ctrl;
        out_data  <= skid_data;
      end else if (in_xfer) begin
        out_valid <= 1'b1;
        out_ctrl  <= in_ctrl;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
        out_ctrl  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed stimulus pushes accepted beats,
// a negedge monitor pops and compares each emitted beat.
module tb_pipe_stage_reg;

  localparam int CW = 5;
  localparam int DW = 102;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [CW+DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  // Monitor / scoreboard
  initial begin
    logic [CW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst || flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {out_ctrl, out_data}, '0);
            if ({out_ctrl, out_data} == '0) begin
              bad++;
              $display("FAIL unexpected_beat: got zero beat want none");
            end
          end else begin
            e = exp_q.pop_front();
            check("beat", {out_ctrl, out_data}, e);
          end
        end
        if (!out_valid) check("bubble_ctrl", out_ctrl, 0);
        if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 5'b11111, 102'h3);
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_ctrl", out_ctrl, 0);
    check("rst_data", out_data, 0);
    cyc();
    cyc();
    check("rst_hold_valid", out_valid, 0);
    check("rst_hold_ctrl", out_ctrl, 0);
    rst = 1'b0;
    drive(1'b0, 5'b11111, '0);
    cyc();
    check("post_rst_valid", out_valid, 0);
    check("post_rst_ctrl", out_ctrl, 0);
    check("post_rst_data", out_data, 0);
    check("post_rst_ready", in_ready, 1);

    // Streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CW'(i), DW'(i));
      cyc();
      check("stream_valid", out_valid, 1);
      check("stream_data", out_data, i);
      check("stream_ctrl", out_ctrl, i);
    end
    drive(1'b0, '0, '0);
    cyc();
    check("stream_end_valid", out_valid, 0);
    check("stream_end_ctrl", out_ctrl, 0);

    // Stall with A5 held, extra beat 5A offered
    out_ready = 1'b0;
    drive(1'b1, 5'b00001, 102'hA5);
    cyc();
    drive(1'b1, 5'b00010, 102'h5A);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("stall_in_ready", in_ready, (SKID && k == 0) ? 1 : 0);
      cyc();
      check("stall_valid", out_valid, 1);
      check("stall_ctrl", out_ctrl, 5'b00001);
      check("stall_data", out_data, 102'hA5);
    end
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    check("stall_drained", out_valid, 0);

    // Skid ordering 0x10 then 0x11
    out_ready = 1'b0;
    drive(1'b1, 5'd3, 102'h10);
    cyc();
    check("order_first", out_data, 102'h10);
    drive(1'b1, 5'd4, 102'h11);
    #1;
    check("order_in_ready", in_ready, SKID ? 1 : 0);
    cyc();
    out_ready = 1'b1;
    if (SKID) drive(1'b0, '0, '0);
    cyc();
    check("order_valid", out_valid, 1);
    check("order_data", out_data, 102'h11);
    check("order_ctrl", out_ctrl, 5'd4);
    drive(1'b0, '0, '0);
    cyc();
    check("order_end", out_valid, 0);

    // Flush with output (and skid, if present) occupied
    out_ready = 1'b0;
    drive(1'b1, 5'b01001, 102'h20);
    cyc();
    check("pre_flush_ctrl", out_ctrl, 5'b01001);
    drive(1'b1, 5'b00010, 102'h21);
    cyc();
    check("pre_flush_ready", in_ready, 0);
    flush = 1'b1;
    drive(1'b1, 5'b11111, 102'h22);
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("flush_valid", out_valid, 0);
    check("flush_ctrl", out_ctrl, 0);
    check("flush_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      check("flush_no_beat", out_valid, 0);
    end

    // Bubble control
    drive(1'b0, 5'b11111, 102'hFF);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("bubble_valid", out_valid, 0);
      check("bubble_ctrl_dir", out_ctrl, 0);
    end

    // Reset mid-stall
    out_ready = 1'b0;
    drive(1'b1, 5'b10000, 102'h30);
    cyc();
    drive(1'b1, 5'b01000, 102'h31);
    cyc();
    drive(1'b0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_ctrl", out_ctrl, 0);
    check("midrst_data", out_data, 0);
    cyc();
    rst = 1'b0;
    #1;
    check("midrst_ready", in_ready, 1);
    check("midrst_valid_after", out_valid, 0);

    out_ready = 1'b1;
    cyc();
    cyc();
    check("queue_empty", exp_q.size(), 0);
    check("beats_out", n_out, SKID ? 12 : 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
